gray_cnt_bank: RTL
==================

# gray_cnt_bank

Multi-channel event counter bank that keeps binary and Gray-coded counts for CH independent event inputs, with wrap or saturate mode, per-channel clear, sticky overflow and a coherent all-channel snapshot handshake. It is the parametrised, single-clock source half of our cross-clock counter path. Each channel's registered Gray output changes by at most one bit per cycle, except on clear, so a destination domain can sample it through a 2-FF synchroniser.

## Interface
Parameters:
- CH, 4, number of counter channels (1..32)
- W, 8, counter width in bits (2..32)
- SAT, 0, overflow mode: 0 = wrap modulo 2^W, 1 = saturate at 2^W-1

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- inc  in  [CH-1:0]  per-channel increment request, +1 per cycle when high
- clr  in  [CH-1:0]  per-channel synchronous clear
- cnt_bin  out  [CH-1:0][W-1:0]  registered binary count
- cnt_gray  out  [CH-1:0][W-1:0]  registered Gray count, equal to bin ^ (bin >> 1)
- ovf  out  [CH-1:0]  sticky overflow / saturation flag
- snap_req  in  1  snapshot request, level-sampled in IDLE
- snap_valid  out  1  snapshot data valid
- snap_ack  in  1  consumer has taken the snapshot
- snap_gray  out  [CH-1:0][W-1:0]  frozen copy of cnt_gray for all channels

## Operation
- Per channel, priority: rst > clr > inc.
  - clr[i]: bin goes to 0, gray goes to 0, ovf[i] goes to 0. A concurrent inc[i] is dropped.
  - inc[i], bin < 2^W-1: bin goes to bin+1.
  - inc[i], bin = 2^W-1, SAT=0: bin goes to 0 and ovf[i] is set.
  - inc[i], bin = 2^W-1, SAT=1: bin holds and ovf[i] is set.
- ovf is sticky. Only clr[i] or rst clears it.
- cnt_gray is registered from the next-state binary, not derived from cnt_bin, so it updates on the same edge as cnt_bin.
  - Wrap from max to 0 is a single-bit Gray change; for W=8 that is 0x80 to 0x00.
  - Saturation produces no Gray change.
  - clr is the only multi-bit Gray change. Consumers treat it as a discontinuity.
- Snapshot FSM with two states:
  - IDLE: snap_valid=0. If snap_req=1, capture snap_gray from the current cnt_gray (values before this edge's increments) and go to HOLD.
  - HOLD: snap_valid=1 and snap_gray is frozen. On snap_ack=1, go to IDLE.
  - snap_req is ignored in HOLD.
  - snap_ack is ignored in IDLE.
  - Counters keep running during HOLD.
- Reset values: cnt_bin, cnt_gray, ovf, snap_gray all 0; snap_valid 0; FSM in IDLE.
- rst mid-HOLD drops the snapshot: snap_valid=0 in the next cycle.

## Timing
- inc or clr sampled at edge k is visible on cnt_bin, cnt_gray and ovf after edge k. Latency is 1 cycle.
- snap_req high at edge k:
  - snap_valid=1 after edge k.
  - snap_gray holds the cnt_gray values present during the cycle before edge k.
- snap_ack high at edge m while in HOLD: snap_valid=0 after edge m.
- Earliest next capture is edge m+1, so there is at least one IDLE cycle between snapshots.
- No combinational paths from inputs to outputs.

## Structure
- Package gray_cnt_pkg holds:
  - function bin2gray(W-generic via a parameterised class or a fixed-32 version plus slicing)
  - function gray2bin, used by the bench and by downstream sync logic
  - typedef enum logic {SNAP_IDLE, SNAP_HOLD} snap_state_e
- Sub-module gray_cnt_chan:
  - one channel: bin/gray/ovf registers plus the wrap/saturate logic, parameters W and SAT
  - instantiated CH times in a generate loop
  - the top adds the snapshot FSM and the snap_gray register bank

## Test plan
- Reset then idle: rst held 3 cycles, then release → all outputs 0, snap_valid=0. Assert rst mid-count on ch0 at bin=17 → cnt_bin[0]=0 and ovf=0 after the edge.
- Wrap, W=8, SAT=0: ch1 incremented 256 times → cnt_bin[1]=0, cnt_gray[1]=0x00, ovf[1]=1. Check every cycle that the Gray Hamming distance ≤1.
- Saturate, W=8, SAT=1: ch2 incremented 300 times → cnt_bin[2]=255, cnt_gray[2]=0x80, ovf[2]=1. Gray is unchanged after the first saturation.
- Clear priority: ch3 at 40 with inc[3]=1 and clr[3]=1 in the same cycle → cnt_bin[3]=0 and ovf[3]=0. Next cycle with inc only → 1.
- Snapshot coherence: ch0..3 counts 5/9/0/200, all incrementing; snap_req pulsed → snap_gray equals bin2gray(5, 9, 0, 200) and snap_valid=1. Values hold for 10 cycles without snap_ack while the live counts advance. A second snap_req during HOLD is ignored.
- Handshake/reset: snap_ack → snap_valid=0 next cycle. snap_req plus snap_ack held high continuously → valid toggles 1,0,1,0. rst during HOLD → snap_valid=0 and snap_gray=0.

Source files
------------

// File: rtl/gray_cnt_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gray_cnt_pkg                                                       |
// | Shared types and Gray-code helpers for the Gray counter bank.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package gray_cnt_pkg;

    typedef enum logic {
        SNAP_IDLE = 1'b0,
        SNAP_HOLD = 1'b1
    } snap_state_e;

    // Fixed 32-bit versions; narrower users zero-extend and truncate.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_cnt_chan.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gray_cnt_chan                                                      |
// | One counter channel: binary, Gray and sticky overflow registers.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module gray_cnt_chan
    import gray_cnt_pkg::*;
#(
    parameter int W   = 8,
    parameter int SAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt_bin,
    output logic [W-1:0] cnt_gray,
    output logic         ovf
);

    localparam logic [W-1:0] c_max = '1;

    logic [W-1:0] r_bin;
    logic [W-1:0] r_gray;
    logic         r_ovf;
    logic [W-1:0] w_bin_nxt;
    logic [W-1:0] w_gray_nxt;
    logic         w_ovf_nxt;

    always_comb begin
        w_bin_nxt = r_bin;
        w_ovf_nxt = r_ovf;
        if (clr) begin
            w_bin_nxt = '0;
            w_ovf_nxt = 1'b0;
        end else if (inc) begin
            if (r_bin == c_max) begin
                w_bin_nxt = (SAT != 0) ? c_max : '0;
                w_ovf_nxt = 1'b1;
            end else begin
                w_bin_nxt = r_bin + 1'b1;
            end
        end
        // Gray follows the next-state binary so both registers move together.
        w_gray_nxt = W'(bin2gray(32'(w_bin_nxt)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_bin  <= w_bin_nxt;
            r_gray <= w_gray_nxt;
            r_ovf  <= w_ovf_nxt;
        end
    end

    assign cnt_bin  = r_bin;
    assign cnt_gray = r_gray;
    assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: rtl/gray_cnt_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gray_cnt_bank                                                      |
// | CH-channel Gray/binary event counters with coherent snapshot.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module gray_cnt_bank
    import gray_cnt_pkg::*;
#(
    parameter int CH  = 4,
    parameter int W   = 8,
    parameter int SAT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH-1:0]        inc,
    input  logic [CH-1:0]        clr,
    output logic [CH-1:0][W-1:0] cnt_bin,
    output logic [CH-1:0][W-1:0] cnt_gray,
    output logic [CH-1:0]        ovf,
    input  logic                 snap_req,
    output logic                 snap_valid,
    input  logic                 snap_ack,
    output logic [CH-1:0][W-1:0] snap_gray
);

    logic [CH-1:0][W-1:0] w_cnt_gray;
    snap_state_e          r_state;
    logic                 r_snap_valid;
    logic [CH-1:0][W-1:0] r_snap_gray;

    for (genvar i = 0; i < CH; i++) begin : g_chan
        gray_cnt_chan #(
            .W   (W),
            .SAT (SAT)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .inc      (inc[i]),
            .clr      (clr[i]),
            .cnt_bin  (cnt_bin[i]),
            .cnt_gray (w_cnt_gray[i]),
            .ovf      (ovf[i])
        );
    end

    // Capture takes the pre-edge Gray values so all channels are coherent.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SNAP_IDLE;
            r_snap_valid <= 1'b0;
            r_snap_gray  <= '0;
        end else begin
            case (r_state)
                SNAP_IDLE: begin
                    if (snap_req) begin
                        r_snap_gray  <= w_cnt_gray;
                        r_snap_valid <= 1'b1;
                        r_state      <= SNAP_HOLD;
                    end
                end
                SNAP_HOLD: begin
                    if (snap_ack) begin
                        r_snap_valid <= 1'b0;
                        r_state      <= SNAP_IDLE;
                    end
                end
                default: begin
                    r_snap_valid <= 1'b0;
                    r_state      <= SNAP_IDLE;
                end
            endcase
        end
    end

    assign cnt_gray   = w_cnt_gray;
    assign snap_valid = r_snap_valid;
    assign snap_gray  = r_snap_gray;

endmodule
`default_nettype wire
